// File: rtl/round_key_file.sv
// round_key_file -- DEPTH x WIDTH round-key store with per-entry valid bits.
// Supports random reads, and a sequential sweep that reads indices
// 0..seq_last. Every read has one cycle of latency.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   clr                  invalidate all entries and abort any sweep
//   wr_en/wr_addr/wr_data   key write; wr_addr >= DEPTH is ignored
//   rd_req/rd_addr       random-read request (dropped while a sweep runs)
//   seq_start/seq_last   begin a sweep over 0..seq_last (clamped to DEPTH-1)
//   rd_valid/rd_data/rd_miss   read response, one cycle after issue
//   seq_busy             sweep in progress
//   seq_done             accompanies the response for the final sweep index
//   valid_cnt            number of valid entries
module round_key_file #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_req,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   input  logic                       seq_start,
   input  logic [$clog2(DEPTH)-1:0]   seq_last,
   output logic                       rd_valid,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_miss,
   output logic                       seq_busy,
   output logic                       seq_done,
   output logic [$clog2(DEPTH):0]     valid_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [DEPTH-1:0]  valid;
   logic [AW-1:0]     seq_idx;
   logic [AW-1:0]     seq_last_q;
   logic              seq_issue;
   logic              rd_issue;
   logic              last_issue;
   logic [AW-1:0]     rd_idx;
   logic              wr_ok;
   logic              rd_in_range;
   logic              bypass;
   logic              hit;
   logic [WIDTH-1:0]  hit_data;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (seq_start && !clr) state_nx = SWEEP;
         SWEEP: if (clr || seq_idx == seq_last_q) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- FSM: outputs / read issue ----------------
   always_comb begin
      seq_busy   = (state == SWEEP);
      seq_issue  = (state == SWEEP);
      rd_issue   = seq_issue || rd_req;
      rd_idx     = seq_issue ? seq_idx : rd_addr;
      // A clr in the final issue cycle aborts the sweep, so no seq_done.
      last_issue = seq_issue && (seq_idx == seq_last_q) && !clr;
   end

   // Sweep index and latched (clamped) final index.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_idx    <= '0;
         seq_last_q <= '0;
      end else if (state == IDLE) begin
         seq_idx <= '0;
         if (seq_start)
            seq_last_q <= ({1'b0, seq_last} >= DEPTH_W) ? LAST_IDX : seq_last;
      end else begin
         seq_idx <= seq_idx + AW'(1);
      end
   end

   // ---------------- storage ----------------
   // clr wins over a same-cycle write, so the write is suppressed entirely.
   assign wr_ok       = wr_en && !clr && ({1'b0, wr_addr} < DEPTH_W);
   assign rd_in_range = ({1'b0, rd_idx} < DEPTH_W);

   always_ff @(posedge clk) begin
      if (wr_ok && !rst) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         valid     <= '0;
         valid_cnt <= '0;
      end else if (wr_ok && !valid[wr_addr]) begin
         valid[wr_addr] <= 1'b1;
         valid_cnt      <= valid_cnt + (AW+1)'(1);
      end
   end

   // ---------------- read path ----------------
   // Reads see pre-clear valid bits; a same-cycle write to the read index
   // forwards its data.
   always_comb begin
      bypass   = wr_ok && (wr_addr == rd_idx);
      hit      = bypass || (rd_in_range && valid[rd_idx]);
      hit_data = '0;
      if (bypass)   hit_data = wr_data;
      else if (hit) hit_data = mem[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_miss  <= 1'b0;
         seq_done <= 1'b0;
      end else begin
         rd_valid <= rd_issue;
         rd_data  <= (rd_issue && hit) ? hit_data : '0;
         rd_miss  <= rd_issue && !hit;
         seq_done <= last_issue;
      end
   end

endmodule
